// File: rtl/alu_cmd_host.sv
// ============================================================================
//  Module      : alu_cmd_host
//  Description : Host-side initiator for the UART ALU. Sends a 5-byte command
//                frame, then parses, checks and returns the 8-byte response.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_cmd_host #(
    parameter int DBITS   = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DBITS-1:0]   cmd_num1,
    input  logic [DBITS-1:0]   cmd_num2,
    input  logic [2:0]         cmd_sel,
    output logic               tx_start,
    output logic [DBITS-1:0]   tx_data,
    input  logic               tx_done,
    input  logic [DBITS-1:0]   rx_data,
    input  logic               rx_done,
    output logic               rsp_valid,
    output logic [2*DBITS-1:0] rsp_result,
    output logic [1:0]         rsp_error,
    output logic               busy
);

    localparam int c_TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [DBITS-1:0] c_CMD_HDR  = DBITS'(8'h0C);
    localparam logic [DBITS-1:0] c_CMD_END  = DBITS'(8'hFF);
    localparam logic [DBITS-1:0] c_RSP_HDR  = DBITS'(8'h20);
    localparam logic [DBITS-1:0] c_RSP_TAIL = DBITS'(8'h0A);
    localparam logic [DBITS-1:0] c_RSP_END  = DBITS'(8'hFF);

    localparam logic [1:0] c_ERR_OK    = 2'd0;
    localparam logic [1:0] c_ERR_FRAME = 2'd1;
    localparam logic [1:0] c_ERR_ECHO  = 2'd2;
    localparam logic [1:0] c_ERR_TMO   = 2'd3;

    logic [1:0]         r_state;
    logic [DBITS-1:0]   r_num1;
    logic [DBITS-1:0]   r_num2;
    logic [2:0]         r_sel;
    logic [2:0]         r_tx_idx;
    logic               r_tx_start;
    logic [DBITS-1:0]   r_tx_data;
    logic [2:0]         r_rx_idx;
    logic [DBITS-1:0]   r_echo1;
    logic [DBITS-1:0]   r_echo2;
    logic [DBITS-1:0]   r_echo3;
    logic [DBITS-1:0]   r_res_hi;
    logic [DBITS-1:0]   r_res_lo;
    logic [DBITS-1:0]   r_tail;
    logic [c_TMO_W-1:0] r_tmo;
    logic               r_rsp_valid;
    logic [2*DBITS-1:0] r_rsp_result;
    logic [1:0]         r_rsp_error;

    logic [DBITS-1:0]   w_sel_byte;
    logic [2:0]         w_next_idx;
    logic [DBITS-1:0]   w_next_byte;
    logic               w_frame_err;
    logic               w_echo_err;
    logic               w_tmo_fire;

    assign w_sel_byte = {{(DBITS-3){1'b0}}, r_sel};
    assign w_next_idx = r_tx_idx + 3'd1;

    always_comb begin
        w_next_byte = c_CMD_END;
        case (w_next_idx)
            3'd1:    w_next_byte = r_num1;
            3'd2:    w_next_byte = r_num2;
            3'd3:    w_next_byte = w_sel_byte;
            default: w_next_byte = c_CMD_END;
        endcase
    end

    // Byte 7 is evaluated as it arrives, so it is compared straight from rx_data.
    assign w_frame_err = (r_tail != c_RSP_TAIL) || (rx_data != c_RSP_END);
    assign w_echo_err  = (r_echo1 != r_num1) || (r_echo2 != r_num2) ||
                         (r_echo3 != w_sel_byte);

    // Fires one cycle early so rsp_valid lands TIMEOUT cycles after the last byte.
    assign w_tmo_fire = (r_tmo == c_TMO_W'(TIMEOUT - 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_num1       <= '0;
            r_num2       <= '0;
            r_sel        <= '0;
            r_tx_idx     <= '0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_rx_idx     <= '0;
            r_echo1      <= '0;
            r_echo2      <= '0;
            r_echo3      <= '0;
            r_res_hi     <= '0;
            r_res_lo     <= '0;
            r_tail       <= '0;
            r_tmo        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_error  <= '0;
        end else begin
            r_tx_start  <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid) begin
                        r_num1     <= cmd_num1;
                        r_num2     <= cmd_num2;
                        r_sel      <= cmd_sel;
                        r_tx_idx   <= '0;
                        r_tx_start <= 1'b1;
                        r_tx_data  <= c_CMD_HDR;
                        r_state    <= c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    if (tx_done) begin
                        if (r_tx_idx == 3'd4) begin
                            r_rx_idx <= '0;
                            r_tmo    <= '0;
                            r_state  <= c_ST_WAIT;
                        end else begin
                            r_tx_idx   <= w_next_idx;
                            r_tx_start <= 1'b1;
                            r_tx_data  <= w_next_byte;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (rx_done) begin
                        r_tmo <= '0;
                        case (r_rx_idx)
                            3'd0: if (rx_data == c_RSP_HDR) r_rx_idx <= 3'd1;
                            3'd1: begin r_echo1  <= rx_data; r_rx_idx <= 3'd2; end
                            3'd2: begin r_echo2  <= rx_data; r_rx_idx <= 3'd3; end
                            3'd3: begin r_echo3  <= rx_data; r_rx_idx <= 3'd4; end
                            3'd4: begin r_res_hi <= rx_data; r_rx_idx <= 3'd5; end
                            3'd5: begin r_res_lo <= rx_data; r_rx_idx <= 3'd6; end
                            3'd6: begin r_tail   <= rx_data; r_rx_idx <= 3'd7; end
                            default: begin
                                r_rsp_result <= {r_res_hi, r_res_lo};
                                if (w_frame_err)
                                    r_rsp_error <= c_ERR_FRAME;
                                else if (w_echo_err)
                                    r_rsp_error <= c_ERR_ECHO;
                                else
                                    r_rsp_error <= c_ERR_OK;
                                r_rsp_valid <= 1'b1;
                                r_rx_idx    <= '0;
                                r_state     <= c_ST_DONE;
                            end
                        endcase
                    end else if (w_tmo_fire) begin
                        r_rsp_result <= '0;
                        r_rsp_error  <= c_ERR_TMO;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= c_ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (r_state == c_ST_IDLE);
    assign busy       = ~cmd_ready;
    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_error  = r_rsp_error;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_host.sv
// ============================================================================
//  Module      : tb_alu_cmd_host
//  Description : Table-driven self-checking bench for alu_cmd_host.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_cmd_host;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_num1 = '0;
    logic [7:0]  cmd_num2 = '0;
    logic [2:0]  cmd_sel = '0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_done = 1'b0;
    logic        rsp_valid;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_error;
    logic        busy;

    alu_cmd_host #(.DBITS(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_num1(cmd_num1), .cmd_num2(cmd_num2), .cmd_sel(cmd_sel),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .rx_data(rx_data), .rx_done(rx_done),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       n1;
        logic [7:0]       n2;
        logic [2:0]       sel;
        logic [0:9][7:0]  rx;
        int               nb;
        logic [15:0]      res;
        logic [1:0]       err;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    int         rsp_cnt = 0;
    logic [7:0] sent[$];
    vec_t       vecs[6];

    always @(posedge clk) rsp_cnt <= rsp_cnt + (rsp_valid === 1'b1 ? 1 : 0);

    // Transmitter model: record each byte and answer with tx_done after a few cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1 tx_done = 1'b0;
            #1;
            if (tx_start === 1'b1) begin
                sent.push_back(tx_data);
                repeat (3) @(posedge clk);
                #1 tx_done = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] n1, input logic [7:0] n2,
                                input logic [2:0] sel, input logic [0:9][7:0] rx,
                                input int nb, input logic [15:0] res,
                                input logic [1:0] err);
        vec_t v;
        v.n1 = n1; v.n2 = n2; v.sel = sel; v.rx = rx; v.nb = nb;
        v.res = res; v.err = err;
        return v;
    endfunction

    task automatic issue(input logic [7:0] n1, input logic [7:0] n2, input logic [2:0] sel,
                         input string tag);
        cmd_num1 = n1; cmd_num2 = n2; cmd_sel = sel; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk({tag, "_txstart_n1"}, {63'd0, tx_start}, 64'd1);
        chk({tag, "_txdata_hdr"}, {56'd0, tx_data}, 64'h0C);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_frame(input logic [7:0] n1, input logic [7:0] n2,
                              input logic [2:0] sel, input string tag);
        logic [39:0] fr;
        for (int i = 0; i < 200 && sent.size() < 5; i++) begin
            @(posedge clk); #1;
        end
        repeat (6) @(posedge clk);
        #1;
        fr = '0;
        for (int i = 0; i < 5; i++) fr = {fr[31:0], (i < sent.size()) ? sent[i] : 8'h00};
        chk({tag, "_frame_len"}, 64'(sent.size()), 64'd5);
        chk({tag, "_frame"}, {24'd0, fr}, {24'd0, 8'h0C, n1, n2, 5'd0, sel, 8'hFF});
    endtask

    task automatic send_rx(input logic [7:0] b);
        repeat (2) @(posedge clk);
        #1 rx_data = b; rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int base;
        sent.delete();
        base = rsp_cnt;
        issue(v.n1, v.n2, v.sel, tag);
        wait_frame(v.n1, v.n2, v.sel, tag);
        for (int i = 0; i < v.nb; i++) send_rx(v.rx[i]);
        chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
        chk({tag, "_ready_in_done"}, {63'd0, cmd_ready}, 64'd0);
        chk({tag, "_result"}, {48'd0, rsp_result}, {48'd0, v.res});
        chk({tag, "_error"}, {62'd0, rsp_error}, {62'd0, v.err});
        @(posedge clk);
        #1;
        chk({tag, "_rsp_valid_drop"}, {63'd0, rsp_valid}, 64'd0);
        chk({tag, "_ready_back"}, {63'd0, cmd_ready}, 64'd1);
        chk({tag, "_result_held"}, {48'd0, rsp_result}, {48'd0, v.res});
        chk({tag, "_pulses"}, 64'(rsp_cnt - base), 64'd1);
    endtask

    initial begin
        int n;
        int base;
        vecs[0] = mk(8'h05, 8'h03, 3'd1,
                     {8'h20, 8'h05, 8'h03, 8'h01, 8'h00, 8'h08, 8'h0A, 8'hFF, 16'h0},
                     8, 16'h0008, 2'd0);
        vecs[1] = mk(8'hFF, 8'hFF, 3'd3,
                     {8'h20, 8'hFF, 8'hFF, 8'h03, 8'hFE, 8'h01, 8'h0A, 8'hFF, 16'h0},
                     8, 16'hFE01, 2'd0);
        vecs[2] = mk(8'h09, 8'h04, 3'd2,
                     {8'h33, 8'h44, 8'h20, 8'h09, 8'h04, 8'h02, 8'h00, 8'h05, 8'h0A, 8'hFF},
                     10, 16'h0005, 2'd0);
        vecs[3] = mk(8'h05, 8'h03, 3'd1,
                     {8'h20, 8'h05, 8'h03, 8'h01, 8'h00, 8'h08, 8'h0D, 8'hFF, 16'h0},
                     8, 16'h0008, 2'd1);
        vecs[4] = mk(8'h05, 8'h03, 3'd1,
                     {8'h20, 8'h06, 8'h03, 8'h01, 8'h00, 8'h08, 8'h0A, 8'hFF, 16'h0},
                     8, 16'h0008, 2'd2);
        // Bad end byte and bad echo together: framing wins.
        vecs[5] = mk(8'h10, 8'h04, 3'd4,
                     {8'h20, 8'h11, 8'h04, 8'h04, 8'h00, 8'h04, 8'h0A, 8'hFE, 16'h0},
                     8, 16'h0004, 2'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_tx_start", {63'd0, tx_start}, 64'd0);
        chk("rst_tx_data", {56'd0, tx_data}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_result", {48'd0, rsp_result}, 64'd0);
        chk("rst_rsp_error", {62'd0, rsp_error}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Timeout after three bytes; a second request during SEND must be ignored.
        sent.delete();
        issue(8'h05, 8'h03, 3'd1, "tmo");
        cmd_num1 = 8'hAA; cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("tmo_ready_in_send", {63'd0, cmd_ready}, 64'd0);
        wait_frame(8'h05, 8'h03, 3'd1, "tmo");
        send_rx(8'h20);
        send_rx(8'h05);
        send_rx(8'h03);
        n = 0;
        while (rsp_valid !== 1'b1 && n < TMO + 20) begin
            @(posedge clk); #1; n++;
        end
        chk("tmo_latency", 64'(n), 64'(TMO - 1));
        chk("tmo_error", {62'd0, rsp_error}, 64'd3);
        chk("tmo_result", {48'd0, rsp_result}, 64'd0);
        @(posedge clk);
        #1;
        chk("tmo_ready_back", {63'd0, cmd_ready}, 64'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("tmo_no_queued_cmd", 64'(sent.size()), 64'd5);

        // Reset while byte 2 is being launched.
        sent.delete();
        base = rsp_cnt;
        issue(8'h12, 8'h34, 3'd1, "rst");
        n = 0;
        while (!(tx_start === 1'b1 && tx_data == 8'h34) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("rst_saw_byte2", {63'd0, tx_start}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_tx_start", {63'd0, tx_start}, 64'd0);
        chk("rst_async_ready", {63'd0, cmd_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send_rx(8'h20);
        repeat (12) @(posedge clk);
        #1;
        chk("rst_ready_after", {63'd0, cmd_ready}, 64'd1);
        chk("rst_no_rsp", 64'(rsp_cnt - base), 64'd0);
        run_vec(vecs[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_cmd_host.md
# alu_cmd_host

Host-side command initiator for the UART ALU command processor. It accepts one operation request (two operands plus an opcode) and serialises it as a 5-byte command frame through the byte-level UART transmitter handshake. It then parses the 8-byte response frame arriving from the UART receiver, checks framing and operand echo, and returns the 16-bit result with a status code. It sits between bench/host logic and a Transmitter/Receiver pair sharing one baud tick.

## Interface
- DBITS, 8, byte width (fixed at 8; frame constants depend on it)
- TIMEOUT, 50000, clk cycles allowed between response bytes in WAIT_RESP
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; all state and outputs cleared
- cmd_valid  in  1  request present
- cmd_ready  out  1  high only in IDLE
- cmd_num1  in  8  operand 1
- cmd_num2  in  8  operand 2
- cmd_sel  in  3  opcode (1 ADD, 2 SUB, 3 MUL, 4 DIV)
- tx_start  out  1  one-cycle pulse to the UART transmitter per byte
- tx_data  out  8  byte to send; stable from tx_start until tx_done
- tx_done  in  1  one-cycle pulse, byte fully shifted out
- rx_data  in  8  byte from the UART receiver
- rx_done  in  1  one-cycle pulse, rx_data valid
- rsp_valid  out  1  one-cycle pulse, response complete
- rsp_result  out  16  {res_hi, res_lo}; held until next rsp_valid
- rsp_error  out  2  0 ok, 1 framing, 2 echo mismatch, 3 timeout; held with rsp_result
- busy  out  1  ~cmd_ready

## Operation
- Command frame: 0x0C, num1, num2, {5'b0, sel}, 0xFF.
- Response frame: 0x20, num1, num2, sel, res_hi, res_lo, 0x0A, 0xFF.
- States: IDLE, SEND, WAIT_RESP, DONE.
- IDLE: cmd_ready=1. cmd_valid&&cmd_ready latches num1/num2/sel, clears tx_idx, and enters SEND.
- SEND: pulse tx_start for byte tx_idx, wait for tx_done, then increment. tx_done on byte 4 clears rx_idx and timeout counter and enters WAIT_RESP. rx_done in SEND or IDLE is ignored.
- WAIT_RESP, rx_idx=0: bytes other than 0x20 are discarded and the index is not advanced.
- WAIT_RESP, rx_idx 1..7: each byte is stored positionally. 0xFF inside payload is data, not a terminator. On byte 7, enter DONE.
- Error evaluation on byte 7, in priority order:
  - byte6≠0x0A or byte7≠0xFF → 1.
  - Else echo (bytes 1..3) ≠ latched num1/num2/{5'b0,sel} → 2.
  - Else → 0.
- Timeout: counter increments each WAIT_RESP cycle and clears on rx_done. On reaching TIMEOUT: rsp_error=3, rsp_result=0, enter DONE.
- DONE: rsp_valid=1 for one cycle, then IDLE.
- cmd_valid outside IDLE is ignored (no queueing).

## Timing
- Reset values:
  - IDLE
  - cmd_ready=1, busy=0
  - tx_start=0, tx_data=0
  - rsp_valid=0, rsp_result=0, rsp_error=0
  - all indices/counters 0
- Accept on cycle N. tx_start for byte 0 at N+1. Each next tx_start is 1 cycle after the prior tx_done.
- tx_done for byte 4 at cycle M → WAIT_RESP at M+1.
- rx_done for response byte 7 at cycle K → rsp_valid at K+1; cmd_ready=1 at K+2.
- Timeout fires exactly TIMEOUT cycles after the last rx_done (or WAIT_RESP entry) with no intervening byte.
- Simultaneous tx_done and rx_done in SEND: the rx byte is dropped.
- Reset mid-operation: immediate return to IDLE. tx_start deasserts asynchronously and partial response is discarded; no rsp_valid.

## Test plan
- ADD 0x05+0x03: frame 0C 05 03 01 FF sent. Reply 20 05 03 01 00 08 0A FF → rsp_result=0x0008, rsp_error=0, one rsp_valid pulse.
- MUL 0xFF×0xFF: reply 20 FF FF 03 FE 01 0A FF → rsp_result=0xFE01, rsp_error=0. Embedded 0xFF in payload must not terminate parsing.
- Junk 0x33 0x44 before header, then a valid SUB 0x09−0x04 reply → junk discarded, rsp_result=0x0005, rsp_error=0.
- Reply with byte6=0x0D → rsp_error=1. Reply echoing num1=0x06 for requested 0x05 with correct framing → rsp_error=2.
- TIMEOUT=100, only 3 reply bytes → rsp_error=3, rsp_result=0 exactly 100 cycles after the 3rd rx_done. cmd_valid during SEND is ignored.
- Assert reset during SEND byte 2 → tx_start=0 immediately, cmd_ready=1 after release, no rsp_valid. The next command completes normally.
